// File: rtl/teclado_entry_ctrl.sv
// Keyboard entry sequencer: turns PS/2 scan-code bytes into digit load strobes
// for a bank of holding registers, with backspace, enter and break/extended filtering.
module teclado_entry_ctrl #(
  parameter int N_SLOTS = 4,
  parameter int W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_done_tick,
  input  logic [7:0]         rx_data,
  output logic [N_SLOTS-1:0] load,
  output logic [W-1:0]       d_out,
  output logic [3:0]         slot_ptr,
  output logic               full,
  output logic               entry_done,
  output logic [3:0]         entry_len,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_BRK  = 3'd1,
    S_EXT  = 3'd2,
    S_LOAD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_slot_ptr;
  logic [3:0]         r_target;
  logic [W-1:0]       r_d_out;
  logic [3:0]         r_entry_len;
  logic               r_inc;
  logic               w_is_digit;
  logic [3:0]         w_digit;
  logic               w_full;
  logic               w_empty;
  logic               w_act_digit;
  logic               w_act_bksp;
  logic               w_act_enter;
  logic [N_SLOTS-1:0] w_load;
  logic               w_done;

  always_comb begin
    w_is_digit = 1'b1;
    w_digit    = 4'd0;
    case (rx_data)
      8'h45:   w_digit = 4'd0;
      8'h16:   w_digit = 4'd1;
      8'h1E:   w_digit = 4'd2;
      8'h26:   w_digit = 4'd3;
      8'h25:   w_digit = 4'd4;
      8'h2E:   w_digit = 4'd5;
      8'h36:   w_digit = 4'd6;
      8'h3D:   w_digit = 4'd7;
      8'h3E:   w_digit = 4'd8;
      8'h46:   w_digit = 4'd9;
      default: w_is_digit = 1'b0;
    endcase
  end

  assign w_full      = (r_slot_ptr == 4'(N_SLOTS));
  assign w_empty     = (r_slot_ptr == 4'd0);
  assign w_act_digit = (r_state == S_WAIT) && rx_done_tick && w_is_digit && !w_full;
  assign w_act_bksp  = (r_state == S_WAIT) && rx_done_tick && (rx_data == 8'h66) && !w_empty;
  assign w_act_enter = (r_state == S_WAIT) && rx_done_tick && (rx_data == 8'h5A) && !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_WAIT;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT: begin
        if (rx_done_tick) begin
          if (rx_data == 8'hF0)              w_next = S_BRK;
          else if (rx_data == 8'hE0)         w_next = S_EXT;
          else if (w_act_digit || w_act_bksp) w_next = S_LOAD;
          else if (w_act_enter)              w_next = S_DONE;
        end
      end
      S_BRK:  if (rx_done_tick) w_next = S_WAIT;
      S_EXT:  if (rx_done_tick) w_next = (rx_data == 8'hF0) ? S_BRK : S_WAIT;
      S_LOAD: w_next = S_WAIT;
      S_DONE: w_next = S_WAIT;
      default: w_next = S_WAIT;
    endcase
  end

  // Backspace decrements before LOAD so the strobe targets the slot being cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot_ptr  <= 4'd0;
      r_target    <= 4'd0;
      r_d_out     <= '0;
      r_entry_len <= 4'd0;
      r_inc       <= 1'b0;
    end else begin
      if (w_act_digit) begin
        r_d_out  <= W'(w_digit);
        r_target <= r_slot_ptr;
        r_inc    <= 1'b1;
      end else if (w_act_bksp) begin
        r_d_out    <= '0;
        r_target   <= r_slot_ptr - 4'd1;
        r_slot_ptr <= r_slot_ptr - 4'd1;
        r_inc      <= 1'b0;
      end else if (w_act_enter) begin
        r_entry_len <= r_slot_ptr;
      end
      if (r_state == S_LOAD && r_inc) r_slot_ptr <= r_slot_ptr + 4'd1;
      if (r_state == S_DONE)          r_slot_ptr <= 4'd0;
    end
  end

  always_comb begin
    w_load = '0;
    w_done = 1'b0;
    if (r_state == S_LOAD) w_load = {{(N_SLOTS-1){1'b0}}, 1'b1} << r_target;
    if (r_state == S_DONE) w_done = 1'b1;
  end

  assign load       = w_load;
  assign d_out      = r_d_out;
  assign slot_ptr   = r_slot_ptr;
  assign full       = w_full;
  assign entry_done = w_done;
  assign entry_len  = r_entry_len;
  assign dbg_state  = r_state;

endmodule

// File: doc/teclado_entry_ctrl.md
Name: teclado_entry_ctrl

Overview:
- Sequencing controller between the PS/2 receiver and a bank of N_SLOTS digit holding registers.
- Each register is a parameterised load-enable register: `load` high captures `d_in`, otherwise it holds.
- The block decodes received scan-code bytes, filters out break (F0) and extended (E0) sequences, and maps number-row make codes to BCD digits.
- It writes each digit into the next free register with a one-cycle load strobe, supports backspace and enter, and reports a completed entry.

Parameters:
- N_SLOTS, 4, number of digit registers controlled (2..8).
- W, 8, data width of the holding registers (W >= 4); digits are zero-extended.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, asynchronous, active-low reset; asserted at 0, released at 1.
- rx_done_tick, input, 1, one-cycle pulse from the PS/2 receiver; rx_data is valid in that cycle.
- rx_data, input, 8, received scan-code byte.
- load, output, N_SLOTS, one-hot load strobes, one bit per holding register.
- d_out, output, W, data driven to the `d_in` of every holding register.
- slot_ptr, output, 4, number of digits currently stored, 0..N_SLOTS.
- full, output, 1, high while slot_ptr == N_SLOTS.
- entry_done, output, 1, one-cycle pulse when an entry is committed.
- entry_len, output, 4, digit count of the last committed entry; held until the next commit.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to WAIT.
  - slot_ptr=0, load=0, d_out=0, entry_done=0, entry_len=0.
  - Reset asserted during LOAD aborts the strobe immediately.
- Make-code to digit map:
  - 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9.
  - 66 = backspace, 5A = enter.
  - Every other byte is ignored.
- WAIT, on rx_done_tick:
  - F0: go to BRK.
  - E0: go to EXT.
  - Digit with slot_ptr < N_SLOTS: latch d_out = digit (zero-extended), go to LOAD.
  - Digit with full=1: ignored, stay in WAIT.
  - 66 with slot_ptr > 0: slot_ptr−1, d_out=0, go to LOAD. The cleared slot is the new slot_ptr value.
  - 66 with slot_ptr = 0: ignored.
  - 5A with slot_ptr > 0: go to DONE.
  - 5A with slot_ptr = 0: ignored.
  - Any other byte: ignored.
- BRK: the next rx_done_tick byte is discarded (the key release), then return to WAIT.
- EXT, on the next rx_done_tick:
  - F0: go to BRK.
  - Any other byte: discard (extended keys, including keypad enter, are unsupported) and return to WAIT.
- LOAD (exactly 1 cycle):
  - load[target] = 1 and all other load bits 0; d_out is stable across this cycle.
  - For a digit, target = slot_ptr and slot_ptr increments at the end of the cycle.
  - For backspace, target = the already-decremented slot_ptr.
  - Return to WAIT.
  - The register captures d_out on the edge ending LOAD, so there is 1 cycle of latency from the tick to the load strobe.
- DONE (exactly 1 cycle):
  - entry_done=1 and entry_len=slot_ptr.
  - slot_ptr clears to 0; the registers are not cleared and keep the last entry until overwritten.
  - Return to WAIT.
- load is 0 in every state except LOAD.
- d_out holds its last value outside LOAD.
- full is combinational from slot_ptr.
- An rx_done_tick arriving while in LOAD or DONE is dropped. PS/2 byte spacing (≥ ~1 ms) makes this unreachable in normal operation.
- slot_ptr never exceeds N_SLOTS and never wraps below 0.

Test Plan:
- Reset, then bytes 16, F0, 16 → exactly one pulse, load=0001 with d_out=01, one cycle after the tick; slot_ptr=1; the break byte pair produces no load.
- Bytes 1E,F0,1E, 26,F0,26, 5A,F0,5A after the previous test → load=0010 (d_out=02), then load=0100 (d_out=03); then entry_done for 1 cycle with entry_len=3 and slot_ptr=0.
- Six digit make codes with N_SLOTS=4 → four loads on slots 0..3; full=1 after the fourth; digits 5 and 6 produce no load; slot_ptr stays 4.
- Digits 3D,3E then 66 → load=0010 with d_out=00; slot_ptr=1. Then 66,66 → one more clear on slot 0, and the final 66 is ignored with slot_ptr=0.
- E0,5A then E0,F0,5A → no entry_done and no load; the state returns to WAIT (a following 45 loads 00 into slot 0).
- rst driven low on the same cycle as a LOAD strobe → load drops to 0 asynchronously; slot_ptr=0 and entry_len=0; normal operation after release.
